// File: rtl/led_scan_pkg.sv
// Shared types and sizes for the LED digit scan controller.
package led_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W      = 3;
  localparam int NIB_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_DIGITS-1:0] mask);
    lowest_set = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (mask[k]) lowest_set = SEL_W'(k);
    end
  endfunction

endpackage

// File: rtl/scan_next_dig.sv
// Priority finder: next enabled digit above the current one, wrap flag and
// lowest enabled digit of the mask.
module scan_next_dig
  import led_scan_pkg::*;
(
  input  logic [NUM_DIGITS-1:0] mask,
  input  logic [SEL_W-1:0]      cur,
  output logic [SEL_W-1:0]      next_idx,
  output logic                  wrap,
  output logic [SEL_W-1:0]      low_idx
);

  logic [NUM_DIGITS-1:0] above;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_above
      assign above[gi] = mask[gi] && (SEL_W'(gi) > cur);
    end
  endgenerate

  assign wrap     = ~|above;
  assign next_idx = lowest_set(above);
  assign low_idx  = lowest_set(mask);

endmodule

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit LED bank: steps through the
// enabled digits with a blanking gap at the start of every slot.
module led_scan_ctrl
  import led_scan_pkg::*;
#(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK_CYC  = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic                        i_load,
  input  logic [NUM_DIGITS*NIB_W-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]       i_mask,
  output logic [SEL_W-1:0]            o_sel,
  output logic [NUM_DIGITS-1:0]       o_dig,
  output logic [NIB_W-1:0]            o_nib,
  output logic                        o_blank,
  output logic                        o_frame_start
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam scan_state_e SLOT_ST = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? '1 : '0;

  scan_state_e                 state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;
  logic [SEL_W-1:0]            sel_reg, sel_next;
  logic [NUM_DIGITS*NIB_W-1:0] shadow_data_reg, shadow_data_next;
  logic [NUM_DIGITS-1:0]       shadow_mask_reg, shadow_mask_next;
  logic [NUM_DIGITS*NIB_W-1:0] active_data_reg, active_data_next;
  logic [NUM_DIGITS-1:0]       active_mask_reg, active_mask_next;
  logic                        pending_reg, pending_next;

  logic [SEL_W-1:0]      out_sel_reg, out_sel_next;
  logic [NUM_DIGITS-1:0] out_dig_reg, out_dig_next;
  logic [NIB_W-1:0]      out_nib_reg, out_nib_next;
  logic                  out_blank_reg, out_blank_next;
  logic                  out_fs_reg, out_fs_next;

  logic [SEL_W-1:0]            nxt_idx, cur_low, new_low;
  logic                        nxt_wrap, frame_bound;
  logic [NUM_DIGITS-1:0]       new_mask, onehot;
  logic [NUM_DIGITS*NIB_W-1:0] new_data;

  scan_next_dig u_next (
    .mask     (active_mask_reg),
    .cur      (sel_reg),
    .next_idx (nxt_idx),
    .wrap     (nxt_wrap),
    .low_idx  (cur_low)
  );

  // What the active registers become if a frame boundary happens this cycle.
  assign new_mask = pending_reg ? shadow_mask_reg : active_mask_reg;
  assign new_data = pending_reg ? shadow_data_reg : active_data_reg;
  assign new_low  = pending_reg ? lowest_set(shadow_mask_reg) : cur_low;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    sel_next         = sel_reg;
    active_data_next = active_data_reg;
    active_mask_next = active_mask_reg;
    pending_next     = pending_reg;
    shadow_data_next = shadow_data_reg;
    shadow_mask_next = shadow_mask_reg;
    frame_bound      = 1'b0;
    out_fs_next      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_en) frame_bound = 1'b1;
      end
      default: begin
        if (!i_en) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (nxt_wrap) begin
            frame_bound = 1'b1;
          end else begin
            sel_next   = nxt_idx;
            state_next = SLOT_ST;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (state_reg == ST_BLANK && cnt_reg == BLANK_LAST) state_next = ST_ON;
        end
      end
    endcase

    // Shadow is applied before this cycle's load, so a load here waits a frame.
    if (frame_bound) begin
      active_data_next = new_data;
      active_mask_next = new_mask;
      pending_next     = 1'b0;
      cnt_next         = '0;
      if (new_mask != '0) begin
        state_next  = SLOT_ST;
        sel_next    = new_low;
        out_fs_next = 1'b1;
      end else begin
        state_next = ST_IDLE;
      end
    end

    if (i_load) begin
      shadow_data_next = i_data;
      shadow_mask_next = i_mask;
      pending_next     = 1'b1;
    end
  end

  // Outputs are registered from the next-state values so they line up with it.
  always_comb begin
    onehot         = NUM_DIGITS'(1) << sel_next;
    out_blank_next = (state_next != ST_ON);
    out_dig_next   = DIG_OFF;
    out_sel_next   = out_sel_reg;
    out_nib_next   = out_nib_reg;
    if (state_next == ST_ON) begin
      out_dig_next = ACTIVE_LOW ? ~onehot : onehot;
      out_sel_next = sel_next;
      out_nib_next = active_data_next[{sel_next, 2'b00} +: NIB_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      sel_reg         <= '0;
      shadow_data_reg <= '0;
      shadow_mask_reg <= '0;
      active_data_reg <= '0;
      active_mask_reg <= '0;
      pending_reg     <= 1'b0;
      out_sel_reg     <= '0;
      out_dig_reg     <= DIG_OFF;
      out_nib_reg     <= '0;
      out_blank_reg   <= 1'b1;
      out_fs_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      sel_reg         <= sel_next;
      shadow_data_reg <= shadow_data_next;
      shadow_mask_reg <= shadow_mask_next;
      active_data_reg <= active_data_next;
      active_mask_reg <= active_mask_next;
      pending_reg     <= pending_next;
      out_sel_reg     <= out_sel_next;
      out_dig_reg     <= out_dig_next;
      out_nib_reg     <= out_nib_next;
      out_blank_reg   <= out_blank_next;
      out_fs_reg      <= out_fs_next;
    end
  end

  assign o_sel         = out_sel_reg;
  assign o_dig         = out_dig_reg;
  assign o_nib         = out_nib_reg;
  assign o_blank       = out_blank_reg;
  assign o_frame_start = out_fs_reg;

endmodule
